// File: rtl/layer_output_act_interp.sv
// Output-layer activation stage: LUT address decode, LUT sample capture, interpolate/saturate.
// Define ACT_INTERP_EN for linear interpolation; otherwise S2 emits the LUT base (step activation).
module layer_output_act_interp #(
  parameter int IN_W   = 16,
  parameter int FRAC_W = 12,
  parameter int OUT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic        [IN_W-1:0]  in_data,
  output logic        [3:0]       lut_address,
  input  logic signed [7:0]       lut_base,
  input  logic signed [7:0]       lut_next,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    busy
);

  localparam int PW = 9 + FRAC_W + 1;
  localparam int RW = PW + 1;
  localparam logic signed [RW-1:0] SMAX = RW'(2**(OUT_W-1) - 1);
  localparam logic signed [RW-1:0] SMIN = RW'(-(2**(OUT_W-1)));

  logic                    stall;
  logic                    v0, v1;
  logic        [3:0]       addr0;
  logic        [FRAC_W-1:0] frac0;
  logic signed [7:0]       base1;
  logic signed [RW-1:0]    sum;
  logic signed [OUT_W-1:0] res;

  assign stall       = out_valid && !out_ready;
  assign in_ready    = !stall;
  assign lut_address = addr0;
  assign busy        = v0 | v1 | out_valid;

`ifdef ACT_INTERP_EN
  logic signed [7:0]        next1;
  logic        [FRAC_W-1:0] frac1;
  logic signed [8:0]        diff;
  logic signed [PW-1:0]     prod;
  logic signed [PW-1:0]     shifted;

  always_comb begin
    diff    = $signed({next1[7], next1}) - $signed({base1[7], base1});
    prod    = $signed({{(PW-9){diff[8]}}, diff}) * $signed({{(PW-FRAC_W){1'b0}}, frac1});
    shifted = prod >>> FRAC_W;
    sum     = $signed({{(RW-8){base1[7]}}, base1}) + $signed({shifted[PW-1], shifted});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next1 <= '0;
      frac1 <= '0;
    end else if (!stall) begin
      next1 <= lut_next;
      frac1 <= frac0;
    end
  end
`else
  logic unused_step;
  assign unused_step = ^{lut_next, frac0};

  always_comb begin
    sum = $signed({{(RW-8){base1[7]}}, base1});
  end
`endif

  always_comb begin
    res = sum[OUT_W-1:0];
    if (sum > SMAX)      res = SMAX[OUT_W-1:0];
    else if (sum < SMIN) res = SMIN[OUT_W-1:0];
  end

  // S0 data loads only on acceptance so the LUT address stays put across bubbles and stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0        <= 1'b0;
      addr0     <= '0;
      frac0     <= '0;
      v1        <= 1'b0;
      base1     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (!stall) begin
      v0 <= in_valid;
      if (in_valid) begin
        addr0 <= in_data[IN_W-1:FRAC_W];
        frac0 <= in_data[FRAC_W-1:0];
      end
      v1        <= v0;
      base1     <= lut_base;
      out_valid <= v1;
      if (v1) out_data <= res;
    end
  end

endmodule

// File: tb/tb_layer_output_act_interp.sv
// Scoreboard bench for layer_output_act_interp with a behavioural LUT and floor-rounded reference.
module tb_layer_output_act_interp;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [15:0]       in_data = '0;
  logic [3:0]        lut_address;
  logic signed [7:0] lut_base, lut_next;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic signed [7:0] out_data;
  logic              busy;

  typedef struct {int expv; int acc_edge; bit lat;} item_t;
  item_t q[$];

  int n_cmp = 0, n_bad = 0, cyc = 0, n_in = 0, n_out = 0;
  bit pend = 0;
  int pend_addr = 0;

  layer_output_act_interp #(.IN_W(16), .FRAC_W(12), .OUT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .lut_address(lut_address), .lut_base(lut_base), .lut_next(lut_next),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lut_val(input int i);
    if (i == 0) return 0;
    if (i == 1) return 12;
    if (i <= 7) return 15;
    if (i <= 14) return -15;
    return -12;
  endfunction

  function automatic int nbr(input int c);
    if (c == 7) return 7;
    if (c == 15) return 0;
    return c + 1;
  endfunction

  always_comb begin
    lut_base = 8'(lut_val(int'(lut_address)));
    lut_next = 8'(lut_val(nbr(int'(lut_address))));
  end

  // Reference: value = base + (next-base)*frac/4096, floored, then clamped.
  function automatic int ref_model(input logic [15:0] d);
    int code, fr, b, n, num, r;
    code = int'(d[15:12]);
    fr   = int'(d[11:0]);
    b    = lut_val(code);
    n    = lut_val(nbr(code));
`ifdef ACT_INTERP_EN
    num = b * 4096 + (n - b) * fr;
    r   = num / 4096;
    if ((num % 4096) != 0 && num < 0) r = r - 1;
`else
    r = b + 0 * (n + fr);
`endif
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic drive(input bit v, input logic [15:0] d, input bit ordy, input int expv, input bit lat);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    #1;
    if (pend) begin
      check("lut_address", int'(lut_address), pend_addr);
      pend = 0;
    end
    if (in_valid && in_ready) begin
      q.push_back('{expv, cyc + 1, lat});
      n_in++;
      pend = 1;
      pend_addr = int'(d[15:12]);
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got out_data=%0d expected no output", out_data);
      end else begin
        item_t it;
        it = q.pop_front();
        check("out_data", int'(out_data), it.expv);
        if (it.lat) check("latency", cyc - it.acc_edge, 2);
        n_out++;
      end
    end
  end

  logic [15:0] dir_d [6];
  int          dir_e [6];
  logic [15:0] d;
  int          snap_data, snap_addr;

  initial begin
    dir_d = '{16'h0800, 16'h1000, 16'h7FFF, 16'h8000, 16'hF000, 16'hF800};
`ifdef ACT_INTERP_EN
    dir_e = '{6, 12, 15, -15, -12, -6};
`else
    dir_e = '{0, 12, 15, -15, -12, -12};
`endif
    #1 rst = 1'b1;
    #2;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_lut_address", int'(lut_address), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_in_ready", int'(in_ready), 1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Back-to-back stream of 8 with no stalls
    for (int i = 0; i < 8; i++) begin
      if (i < 6) drive(1'b1, dir_d[i], 1'b1, dir_e[i], 1'b1);
      else begin
        d = 16'($urandom);
        drive(1'b1, d, 1'b1, ref_model(d), 1'b1);
      end
      check("in_ready_stream", int'(in_ready), 1);
    end
    repeat (4) drive(1'b0, '0, 1'b1, 0, 1'b0);

    // Three in flight, then a 5-cycle stall
    for (int i = 0; i < 3; i++) begin
      d = 16'($urandom);
      drive(1'b1, d, 1'b0, ref_model(d), 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      d = 16'($urandom);
      drive(1'b1, d, 1'b0, ref_model(d), 1'b0);
      check("stall_in_ready", int'(in_ready), 0);
      check("stall_out_valid", int'(out_valid), 1);
      if (i == 0) begin
        snap_data = int'(out_data);
        snap_addr = int'(lut_address);
      end else begin
        check("stall_out_data", int'(out_data), snap_data);
        check("stall_lut_address", int'(lut_address), snap_addr);
      end
    end
    repeat (6) drive(1'b0, '0, 1'b1, 0, 1'b0);
    check("stall_drained", q.size(), 0);

    // Reset with two samples in flight
    for (int i = 0; i < 2; i++) begin
      d = 16'($urandom);
      drive(1'b1, d, 1'b0, ref_model(d), 1'b0);
    end
    drive(1'b0, '0, 1'b0, 0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_busy", int'(busy), 0);
    q.delete();
    pend = 0;
    @(negedge clk) rst = 1'b0;
    repeat (6) drive(1'b0, '0, 1'b1, 0, 1'b0);
    check("postrst_out_valid", int'(out_valid), 0);
    check("postrst_busy", int'(busy), 0);

    // Random traffic with random back-pressure
    n_in = 0;
    n_out = 0;
    for (int i = 0; i < 100; i++) begin
      d = 16'($urandom);
      drive(($urandom % 4) != 0, d, ($urandom % 3) != 0, ref_model(d), 1'b0);
    end
    for (int i = 0; i < 40 && q.size() != 0; i++) drive(1'b0, '0, 1'b1, 0, 1'b0);
    drive(1'b0, '0, 1'b1, 0, 1'b0);
    check("drain_empty", q.size(), 0);
    check("in_out_count", n_out, n_in);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
